dbus_sram_responder: RTL and testbench
======================================

Name: dbus_sram_responder

Overview:
- Responder end of the data bus: answers dbus_req_t requests from the core with dbus_resp_t responses.
- Backs the bus with a word-addressed SRAM model of 64-bit words.
- Handshake latency is fixed and configurable.
- Used as the data-memory stand-in for core-level simulation and as the template for the real memory-side port. It reports protocol and address faults for the bench.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words of backing store (power of two).
- BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.
- LATENCY, 2, cycles from request acceptance to the response cycle (legal range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dreq  in  dbus_req_t  fields: valid, addr[63:0], size (msize_t: 0=1B, 1=2B, 2=4B, 3=8B), strobe[7:0], data[63:0].
- dresp  out  dbus_resp_t  fields: addr_ok, data_ok, data[63:0].
- err  out  1  sticky fault flag.
- err_addr  out  64  address of the first fault since reset.
- txn_count  out  32  number of completed transactions.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0; err=0; err_addr=0; txn_count=0. Memory contents are not cleared.
- If reset is asserted mid-transaction, the transaction is dropped and no write commits.
- All outputs are registered. There is no combinational path from dreq to dresp.
- FSM states are IDLE, WAIT and RESP.
- IDLE: if dreq.valid=1, latch addr, size, strobe and data, load cnt=LATENCY-1, and go to WAIT (or straight to RESP when LATENCY=1).
- WAIT: decrement cnt each cycle. When cnt=0, perform the access and go to RESP.
- If dreq.valid drops during WAIT, abort: go to IDLE, no write, txn_count unchanged.
- Access (edge entering RESP):
  - word index = (addr-BASE_ADDR)>>3.
  - Read data = the full 64-bit word; the core extracts the bytes it needs.
  - Write happens if strobe!=0: byte i of the word is updated with data[8i+7:8i] only where strobe[i]=1.
  - A read and a write to the same word in one access return the pre-write data.
- RESP: dresp.addr_ok=1 and dresp.data_ok=1 for exactly one cycle, with dresp.data valid. txn_count increments by 1 (wraps at 2^32). Next state is IDLE.
- Outside RESP, dresp.addr_ok=0, dresp.data_ok=0 and dresp.data=0.
- Back-to-back requests: a request still valid in the IDLE cycle after RESP is treated as a new transaction. Minimum spacing is LATENCY+1 cycles per transaction.
- Fault conditions:
  - addr<BASE_ADDR.
  - word index ≥ MEM_WORDS.
  - addr not aligned to 2^size.
  - strobe set outside the bytes covered by size/addr[2:0].
- On a fault: still respond in RESP with data=0, no memory write, err<=1. err_addr<=addr only if err was 0; the first fault wins. txn_count still increments.
- Changes to dreq fields after acceptance are ignored; the latched copy is used.

Test Plan:
- LATENCY=2, reset, then write addr=0x8000_0010, size=3, strobe=0xFF, data=0x1122334455667788 → addr_ok=data_ok=1 exactly 2 cycles after acceptance; txn_count=1; err=0.
- Read the same address → data=0x1122334455667788 in the response cycle. Then write strobe=0x0F, data=0xAAAAAAAA_BBBBBBBB, and read back → 0x11223344_BBBBBBBB.
- Hold dreq.valid high continuously for 3 reads → responses at cycles 2, 5 and 8 after the first acceptance; dresp.data_ok is never high two cycles running.
- Write to addr=0x7FFF_FFF8 and then to 0x8000_0003 with size=2 → both respond with data=0; err=1; err_addr=0x7FFF_FFF8; memory unchanged.
- Drop dreq.valid one cycle after a write is accepted → no response and the word is unchanged. Separately, assert reset during WAIT → all outputs return to 0 next cycle and no write occurs.
- LATENCY=1: request in cycle 0 → response in cycle 1. A request held into cycle 2 is accepted again and responds in cycle 3.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency SRAM responder for the data bus with fault reporting
package dbus_pkg;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        err,
  output logic [63:0] err_addr,
  output logic [31:0] txn_count
);
  localparam int IW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [63:0] r_addr, r_wdata, r_data, r_err_addr;
  logic [1:0]  r_size;
  logic [7:0]  r_strb;
  logic        r_ok, r_err;
  logic [31:0] r_txn;
  logic [63:0] r_mem [MEM_WORDS];
  logic        w_access, w_fault, w_mis;
  logic [63:0] w_addr, w_wdata, w_off;
  logic [1:0]  w_size;
  logic [7:0]  w_strb, w_allow;
  logic [IW-1:0] w_idx;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == IDLE ? 4'(LATENCY - 1) : r_cnt - 4'd1;
    end
  end
  // Leaving WAIT on the edge where the counter would reach zero gives exactly LATENCY cycles
  always_comb
    w_next = r_state == RESP ? IDLE :
             !dreq.valid     ? IDLE :
             r_state == IDLE ? (LATENCY == 1 ? RESP : WAIT) :
             r_cnt == 4'd1   ? RESP : WAIT;
  // With LATENCY=1 the access happens on the accepting edge, so use the live request there
  always_comb begin
    w_access = w_next == RESP;
    w_addr   = r_state == IDLE ? dreq.addr   : r_addr;
    w_size   = r_state == IDLE ? dreq.size   : r_size;
    w_strb   = r_state == IDLE ? dreq.strobe : r_strb;
    w_wdata  = r_state == IDLE ? dreq.data   : r_wdata;
    w_off    = w_addr - BASE_ADDR;
    w_idx    = w_off[IW+2:3];
    w_mis    = (w_addr[2:0] & 3'((4'd1 << w_size) - 4'd1)) != 3'd0;
    w_allow  = 8'((16'd1 << (5'd1 << w_size)) - 16'd1) << w_addr[2:0];
    w_fault  = w_addr < BASE_ADDR || (w_off >> 3) >= 64'(MEM_WORDS) || w_mis ||
               (w_strb & ~w_allow) != 8'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ok       <= 1'b0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_txn      <= '0;
    end else begin
      r_ok   <= w_access;
      r_data <= w_access && !w_fault ? r_mem[w_idx] : '0;
      if (w_access) r_txn <= r_txn + 32'd1;
      if (w_access && w_fault) r_err <= 1'b1;
      if (w_access && w_fault && !r_err) r_err_addr <= w_addr;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == IDLE && dreq.valid) begin
      r_addr  <= dreq.addr;
      r_size  <= dreq.size;
      r_strb  <= dreq.strobe;
      r_wdata <= dreq.data;
    end
  end
  always_ff @(posedge clk)
    if (!reset && w_access && !w_fault)
      for (int b = 0; b < 8; b++)
        if (w_strb[b]) r_mem[w_idx][8*b+:8] <= w_wdata[8*b+:8];
  assign dresp     = '{addr_ok: r_ok, data_ok: r_ok, data: r_data};
  assign err       = r_err;
  assign err_addr  = r_err_addr;
  assign txn_count = r_txn;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: directed checks of latency, byte strobes, aborts, faults and LATENCY=1 back-to-back
module tb_dbus_sram_responder;
  import dbus_pkg::*;
  logic clk = 1'b0, reset;
  dbus_req_t  rq_a, rq_b;
  dbus_resp_t rs_a, rs_b;
  logic err_a, err_b;
  logic [63:0] ea_a, ea_b;
  logic [31:0] tc_a, tc_b, exp_txn;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dbus_sram_responder #(.LATENCY(2)) u_a (.clk(clk), .reset(reset), .dreq(rq_a), .dresp(rs_a),
    .err(err_a), .err_addr(ea_a), .txn_count(tc_a));
  dbus_sram_responder #(.LATENCY(1)) u_b (.clk(clk), .reset(reset), .dreq(rq_b), .dresp(rs_b),
    .err(err_b), .err_addr(ea_b), .txn_count(tc_b));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One LATENCY=2 transaction; request fields are scrambled after acceptance to prove they are latched
  task automatic txn(input logic [63:0] addr, input logic [1:0] sz, input logic [7:0] st,
                     input logic [63:0] wd, input logic cd, input logic [63:0] ed);
    rq_a = '{valid: 1'b1, addr: addr, size: msize_t'(sz), strobe: st, data: wd};
    tick;
    rq_a.addr = 64'h8000_0020; rq_a.data = 64'hFFFF_FFFF_FFFF_FFFF; rq_a.strobe = 8'hFF;
    chk("wait_ok", 64'(rs_a.data_ok), 64'd0);
    tick;
    rq_a.valid = 1'b0;
    exp_txn++;
    chk("addr_ok", 64'(rs_a.addr_ok), 64'd1);
    chk("data_ok", 64'(rs_a.data_ok), 64'd1);
    if (cd) chk("rdata", rs_a.data, ed);
    chk("txn", 64'(tc_a), 64'(exp_txn));
    tick;
    chk("idle_ok", 64'(rs_a.data_ok), 64'd0);
    chk("idle_data", rs_a.data, 64'd0);
  endtask

  initial begin
    rq_a = '0; rq_b = '0; reset = 1'b1; exp_txn = 0;
    tick; tick;
    reset = 1'b0;
    chk("rst_addr_ok", 64'(rs_a.addr_ok), 64'd0);
    chk("rst_data_ok", 64'(rs_a.data_ok), 64'd0);
    chk("rst_data", rs_a.data, 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_err_addr", ea_a, 64'd0);
    chk("rst_txn", 64'(tc_a), 64'd0);

    txn(64'h8000_0010, 2'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'd0);
    chk("wr_err", 64'(err_a), 64'd0);
    txn(64'h8000_0010, 2'd3, 8'h00, 64'd0, 1'b1, 64'h1122_3344_5566_7788);
    txn(64'h8000_0010, 2'd3, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b1, 64'h1122_3344_5566_7788);
    txn(64'h8000_0010, 2'd3, 8'h00, 64'd0, 1'b1, 64'h1122_3344_BBBB_BBBB);
    txn(64'h8000_0000, 2'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0);

    rq_a = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'h00, data: 64'd0};
    tick;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("b2b_ok_c%0d", c), 64'(rs_a.data_ok), 64'(c == 2 || c == 5 || c == 8));
      chk($sformatf("b2b_data_c%0d", c), rs_a.data,
          (c == 2 || c == 5 || c == 8) ? 64'h1122_3344_BBBB_BBBB : 64'd0);
      if (c == 8) rq_a.valid = 1'b0;
      tick;
    end
    exp_txn += 3;
    chk("b2b_txn", 64'(tc_a), 64'(exp_txn));

    txn(64'h7FFF_FFF8, 2'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'd0);
    chk("low_err", 64'(err_a), 64'd1);
    chk("low_err_addr", ea_a, 64'h7FFF_FFF8);
    txn(64'h8000_0003, 2'd2, 8'h0F, 64'hCAFE_CAFE_CAFE_CAFE, 1'b1, 64'd0);
    chk("mis_err_addr", ea_a, 64'h7FFF_FFF8);
    txn(64'h8000_0010, 2'd0, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0);
    txn(64'h8000_8000, 2'd3, 8'h00, 64'd0, 1'b1, 64'd0);
    chk("oor_err_addr", ea_a, 64'h7FFF_FFF8);
    txn(64'h8000_0000, 2'd3, 8'h00, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF);
    txn(64'h8000_0010, 2'd3, 8'h00, 64'd0, 1'b1, 64'h1122_3344_BBBB_BBBB);

    rq_a = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'hFF, data: 64'd0};
    tick;
    rq_a.valid = 1'b0;
    tick;
    chk("abort_ok_c2", 64'(rs_a.data_ok), 64'd0);
    tick;
    chk("abort_ok_c3", 64'(rs_a.data_ok), 64'd0);
    chk("abort_txn", 64'(tc_a), 64'(exp_txn));
    txn(64'h8000_0010, 2'd3, 8'h00, 64'd0, 1'b1, 64'h1122_3344_BBBB_BBBB);

    rq_a = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'hFF, data: 64'd0};
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; rq_a.valid = 1'b0;
    chk("mrst_ok", 64'(rs_a.data_ok), 64'd0);
    chk("mrst_err", 64'(err_a), 64'd0);
    chk("mrst_err_addr", ea_a, 64'd0);
    chk("mrst_txn", 64'(tc_a), 64'd0);
    exp_txn = 0;
    tick;
    txn(64'h8000_0010, 2'd3, 8'h00, 64'd0, 1'b1, 64'h1122_3344_BBBB_BBBB);

    rq_b = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'hFF, data: 64'h5555_6666_7777_8888};
    tick;
    chk("l1_ok_c1", 64'(rs_b.data_ok), 64'd1);
    tick;
    chk("l1_ok_c2", 64'(rs_b.data_ok), 64'd0);
    tick;
    rq_b.valid = 1'b0;
    chk("l1_ok_c3", 64'(rs_b.data_ok), 64'd1);
    chk("l1_txn", 64'(tc_b), 64'd2);
    tick;
    chk("l1_ok_c4", 64'(rs_b.data_ok), 64'd0);
    rq_b = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'h00, data: 64'd0};
    tick;
    rq_b.valid = 1'b0;
    chk("l1_rd_ok", 64'(rs_b.data_ok), 64'd1);
    chk("l1_rdata", rs_b.data, 64'h5555_6666_7777_8888);
    chk("l1_err", 64'(err_b), 64'd0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
